// File: rtl/spi_ram_responder.sv
// SPI mode-0 target acting as a 16-bit word RAM: READ (0x03) / WRITE (0x02) + address, then streamed words.
// A parallel backdoor port preloads or patches the array at any time.
module spi_ram_responder #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_cs,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [15:0]           load_data,
  output logic                  busy,
  output logic                  wr_strobe,
  output logic                  cmd_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_RDATA  = 3'd3,
    ST_WDATA  = 3'd4,
    ST_IGNORE = 3'd5
  } state_e;

  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sck_last_q;

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [15:0]     shift_q, shift_d;
  logic [15:0]     tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic            rw_q, rw_d;
  logic            miso_q, miso_d;
  logic            busy_q, busy_d;
  logic            wr_strobe_q, wr_strobe_d;
  logic            cmd_err_q, cmd_err_d;

  logic              cs_s, sck_s, mosi_s;
  logic              sck_rise_s, sck_fall_s;
  logic [7:0]        opcode_s;
  logic [15:0]       wdata_s;
  logic [ADDR_W-1:0] addr_shift_s;
  logic [ADDR_W-1:0] addr_inc_s;
  logic [DEPTH_LOG2-1:0] rd_idx_s;
  logic [DEPTH_LOG2-1:0] wr_idx_s;
  logic [15:0]       rd_data_s;
  logic              spi_we_s;

  logic [15:0] mem [DEPTH];

  // Input synchronisers; CS parks high so a reset never looks like a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      sck_sync_q  <= {SYNC_STAGES{1'b0}};
      mosi_sync_q <= {SYNC_STAGES{1'b0}};
      sck_last_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_last_q  <= sck_sync_q[SYNC_STAGES-1];
    end
  end

  assign cs_s       = cs_sync_q[SYNC_STAGES-1];
  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise_s = sck_s & ~sck_last_q;
  assign sck_fall_s = ~sck_s & sck_last_q;

  assign opcode_s     = {shift_q[6:0], mosi_s};
  assign wdata_s      = {shift_q[14:0], mosi_s};
  assign addr_shift_s = {addr_q[ADDR_W-2:0], mosi_s};
  assign addr_inc_s   = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign wr_idx_s     = addr_q[DEPTH_LOG2-1:0];
  // The fetch address is the just-completed address in ADDR, else the next word of a burst.
  assign rd_idx_s     = (state_q == ST_ADDR) ? addr_shift_s[DEPTH_LOG2-1:0]
                                             : addr_inc_s[DEPTH_LOG2-1:0];
  assign rd_data_s    = mem[rd_idx_s];

  // Word array: SPI write first, backdoor last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (spi_we_s && !(load_en && (load_addr == wr_idx_s))) begin
      mem[wr_idx_s] <= wdata_s;
    end
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // Frame state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 5'd0;
      shift_q     <= 16'd0;
      tx_q        <= 16'd0;
      addr_q      <= {ADDR_W{1'b0}};
      rw_q        <= 1'b0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // Next-state logic: CS high aborts any frame, otherwise decode per state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    miso_d      = miso_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    cmd_err_d   = 1'b0;
    spi_we_s    = 1'b0;

    if ((state_q != ST_IDLE) && cs_s) begin
      state_d = ST_IDLE;
      cnt_d   = 5'd0;
      miso_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          miso_d = 1'b0;
          if (!cs_s) begin
            state_d = ST_CMD;
            cnt_d   = 5'd0;
            busy_d  = 1'b1;
          end else begin
            busy_d  = 1'b0;
          end
        end
        ST_CMD: begin
          miso_d = 1'b0;
          if (sck_rise_s) begin
            shift_d = wdata_s;
            if (cnt_q == 5'd7) begin
              cnt_d = 5'd0;
              case (opcode_s)
                8'h03: begin
                  state_d = ST_ADDR;
                  rw_d    = 1'b0;
                end
                8'h02: begin
                  state_d = ST_ADDR;
                  rw_d    = 1'b1;
                end
                default: begin
                  state_d   = ST_IGNORE;
                  cmd_err_d = 1'b1;
                end
              endcase
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_ADDR: begin
          miso_d = 1'b0;
          if (sck_rise_s) begin
            addr_d = addr_shift_s;
            if (cnt_q == 5'(ADDR_W - 1)) begin
              cnt_d = 5'd0;
              if (rw_q) begin
                state_d = ST_WDATA;
              end else begin
                state_d = ST_RDATA;
                tx_d    = rd_data_s;
              end
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_RDATA: begin
          if (sck_fall_s) begin
            miso_d = tx_q[15];
            tx_d   = {tx_q[14:0], 1'b0};
            if (cnt_q == 5'd15) begin
              cnt_d  = 5'd0;
              addr_d = addr_inc_s;
              tx_d   = rd_data_s;
            end else begin
              cnt_d  = cnt_q + 5'd1;
            end
          end else begin
            miso_d = miso_q;
          end
        end
        ST_WDATA: begin
          miso_d = 1'b0;
          if (sck_rise_s) begin
            shift_d = wdata_s;
            if (cnt_q == 5'd15) begin
              cnt_d       = 5'd0;
              spi_we_s    = 1'b1;
              wr_strobe_d = 1'b1;
              addr_d      = addr_inc_s;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_IGNORE: begin
          miso_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 5'd0;
          miso_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign spi_miso  = miso_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed bench for spi_ram_responder: a bit-banged SPI master with hand-computed expected words.
module tb_spi_ram_responder;

  localparam int H = 6;  // SCK half period in clk cycles

  logic        clk;
  logic        rst_n;
  logic        spi_cs;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [15:0] load_data;
  logic        busy;
  logic        wr_strobe;
  logic        cmd_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int err_cnt = 0;

  spi_ram_responder #(.ADDR_W(16), .DEPTH_LOG2(10), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_cs    (spi_cs),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .cmd_err   (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_strobe) wr_cnt <= wr_cnt + 1;
    if (cmd_err)   err_cnt <= err_cnt + 1;
  end

  task automatic backdoor(input logic [9:0] a, input logic [15:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic xfer(input logic b, output logic m);
    spi_mosi = b;
    repeat (H) @(negedge clk);
    m = spi_miso;
    spi_sck = 1'b1;
    repeat (H) @(negedge clk);
    spi_sck = 1'b0;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    logic m;
    for (int i = n - 1; i >= 0; i--) xfer(v[i], m);
  endtask

  task automatic frame_start();
    spi_cs = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (H) @(negedge clk);
    spi_cs = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  // Reads one word of MISO; counts bit times where busy was low or MISO was high.
  task automatic get_word(output logic [15:0] w, inout int busy_low, inout int miso_hi);
    logic m;
    w = 16'd0;
    for (int i = 0; i < 16; i++) begin
      xfer(1'b0, m);
      w = {w[14:0], m};
      if (busy !== 1'b1) busy_low++;
      if (m !== 1'b0) miso_hi++;
    end
  endtask

  task automatic read_frame(input logic [15:0] a, input int nw,
                            output logic [15:0] w0, output logic [15:0] w1, output int busy_low);
    int hi;
    busy_low = 0; hi = 0; w1 = 16'd0;
    frame_start();
    send(32'h03, 8);
    send({16'd0, a}, 16);
    get_word(w0, busy_low, hi);
    if (nw > 1) get_word(w1, busy_low, hi);
    frame_end();
  endtask

  task automatic test_reset();
    n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (spi_miso !== 1'b0)  begin n_fail++; $display("FAIL reset_miso got %b exp 0", spi_miso); end
    n_cmp++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_wr_strobe got %b exp 0", wr_strobe); end
    n_cmp++; if (cmd_err !== 1'b0)   begin n_fail++; $display("FAIL reset_cmd_err got %b exp 0", cmd_err); end
  endtask

  task automatic test_single_read();
    logic [15:0] w0, w1;
    int bl, e0;
    e0 = err_cnt;
    read_frame(16'h0012, 1, w0, w1, bl);
    n_cmp++; if (w0 !== 16'hA55A) begin n_fail++; $display("FAIL single_read got %h exp a55a", w0); end
    n_cmp++; if (bl !== 0) begin n_fail++; $display("FAIL single_read_busy low_bits got %0d exp 0", bl); end
    n_cmp++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL single_read_cmd_err got %0d exp 0", err_cnt - e0); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_burst();
    logic [15:0] w0, w1;
    int bl;
    read_frame(16'h0012, 2, w0, w1, bl);
    n_cmp++; if (w0 !== 16'hA55A) begin n_fail++; $display("FAIL burst_w0 got %h exp a55a", w0); end
    n_cmp++; if (w1 !== 16'h1234) begin n_fail++; $display("FAIL burst_w1 got %h exp 1234", w1); end
    read_frame(16'hFFFF, 2, w0, w1, bl);
    n_cmp++; if (w0 !== 16'hCAFE) begin n_fail++; $display("FAIL wrap_w0 got %h exp cafe", w0); end
    n_cmp++; if (w1 !== 16'h0F0F) begin n_fail++; $display("FAIL wrap_w1 got %h exp 0f0f", w1); end
  endtask

  task automatic test_write();
    logic [15:0] w0, w1;
    int bl, c0;
    c0 = wr_cnt;
    frame_start();
    send(32'h02, 8);
    send(32'h0040, 16);
    send(32'hBEEF, 16);
    frame_end();
    n_cmp++; if (wr_cnt - c0 !== 1) begin n_fail++; $display("FAIL write_strobes got %0d exp 1", wr_cnt - c0); end
    read_frame(16'h0040, 1, w0, w1, bl);
    n_cmp++; if (w0 !== 16'hBEEF) begin n_fail++; $display("FAIL write_readback got %h exp beef", w0); end
  endtask

  task automatic test_partial_write();
    logic [15:0] w0, w1;
    int bl, c0;
    c0 = wr_cnt;
    frame_start();
    send(32'h02, 8);
    send(32'h0040, 16);
    send(32'h0155, 10);
    frame_end();
    n_cmp++; if (wr_cnt - c0 !== 0) begin n_fail++; $display("FAIL partial_strobes got %0d exp 0", wr_cnt - c0); end
    read_frame(16'h0040, 1, w0, w1, bl);
    n_cmp++; if (w0 !== 16'hBEEF) begin n_fail++; $display("FAIL partial_unchanged got %h exp beef", w0); end
    read_frame(16'h0013, 1, w0, w1, bl);
    n_cmp++; if (w0 !== 16'h1234) begin n_fail++; $display("FAIL partial_next_read got %h exp 1234", w0); end
  endtask

  task automatic test_bad_opcode();
    logic [15:0] w0, w1;
    int bl, hi, e0;
    bl = 0; hi = 0; e0 = err_cnt;
    frame_start();
    send(32'h9F, 8);
    n_cmp++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL badop_cmd_err got %0d exp 1", err_cnt - e0); end
    for (int i = 0; i < 16; i++) begin
      logic m;
      xfer(1'b1, m);
      if (m !== 1'b0) hi++;
    end
    frame_end();
    n_cmp++; if (hi !== 0) begin n_fail++; $display("FAIL badop_miso high_bits got %0d exp 0", hi); end
    n_cmp++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL badop_pulses got %0d exp 1", err_cnt - e0); end
    read_frame(16'h0012, 1, w0, w1, bl);
    n_cmp++; if (w0 !== 16'hA55A) begin n_fail++; $display("FAIL badop_next_read got %h exp a55a", w0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] w0, w1;
    int bl;
    frame_start();
    send(32'h03, 8);
    send(32'h00, 8);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got %b exp 1", busy); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL midrst_busy got %b exp 0", busy); end
    n_cmp++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL midrst_miso got %b exp 0", spi_miso); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    spi_cs = 1'b1;
    repeat (2 * H) @(negedge clk);
    read_frame(16'h0013, 1, w0, w1, bl);
    n_cmp++; if (w0 !== 16'h1234) begin n_fail++; $display("FAIL midrst_next_read got %h exp 1234", w0); end
  endtask

  initial begin
    rst_n = 1'b0; spi_cs = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    load_en = 1'b0; load_addr = 10'd0; load_data = 16'd0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    backdoor(10'h012, 16'hA55A);
    backdoor(10'h013, 16'h1234);
    backdoor(10'h3FF, 16'hCAFE);
    backdoor(10'h000, 16'h0F0F);
    test_single_read();
    test_burst();
    test_write();
    test_partial_write();
    test_bad_opcode();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
